// File: rtl/wb_cache_dm_pkg.sv
// Shared types and helpers for the direct-mapped write-back cache.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Holds the default geometry, the tag-width derivation, the index/tag
// address extractors and the command priority decoder. The extractors work
// on a 64-bit widened address, so any ADDR_W up to 64 can use them; callers
// size-cast the result down to INDEX_W / TAG_W.
package wb_cache_dm_pkg;

    localparam int INDEX_W_DEF = 6;
    localparam int ADDR_W_DEF  = 32;
    localparam int CNT_W_DEF   = 32;
    localparam int WIDE_W      = 64;

    typedef logic [WIDE_W-1:0] wide_t;

    // One command is honoured per cycle; CMD_NONE means no array change.
    typedef enum logic [1:0] {
        CMD_NONE      = 2'd0,
        CMD_WRITEBACK = 2'd1,
        CMD_UPDATE    = 2'd2,
        CMD_STORE     = 2'd3
    } cmd_e;

    // Word-per-line cache: the two low address bits select a byte in the word.
    function automatic int tag_w(input int addr_w, input int index_w);
        return addr_w - index_w - 2;
    endfunction

    function automatic wide_t idx_of(input wide_t a, input int index_w);
        wide_t mask;
        mask = (wide_t'(1) << index_w) - wide_t'(1);
        return (a >> 2) & mask;
    endfunction

    function automatic wide_t tag_of(input wide_t a, input int index_w);
        return a >> (index_w + 2);
    endfunction

    // writeback > update > memwrite; the losers are dropped, not queued.
    function automatic cmd_e pick_cmd(input logic wb, input logic up, input logic mw);
        cmd_e c;
        if (wb)      c = CMD_WRITEBACK;
        else if (up) c = CMD_UPDATE;
        else if (mw) c = CMD_STORE;
        else         c = CMD_NONE;
        return c;
    endfunction

endpackage

// File: rtl/wb_cache_dm_line_array.sv
// Tag/data storage plus per-line valid and dirty flags for the cache.
// Latency: reads are combinational; writes land at the next rising edge.
// Backpressure: none; every write enable is honoured in the cycle it is set.
//
// Ports:
//   clk_i, rst_ni        clock and synchronous active-low reset (flags only)
//   idx_i                line index shared by the read and the write port
//   rd_*_o               contents of line idx_i
//   *_we_i / *_i         independent write enables and values for data,
//                        tag, valid and dirty of line idx_i
module wb_cache_dm_line_array #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 24
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [INDEX_W-1:0] idx_i,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [31:0]        rd_data_o,
    output logic               rd_valid_o,
    output logic               rd_dirty_o,
    input  logic               data_we_i,
    input  logic [31:0]        data_i,
    input  logic               tag_we_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic               valid_we_i,
    input  logic               valid_i,
    input  logic               dirty_we_i,
    input  logic               dirty_i
);

    localparam int LINES = 1 << INDEX_W;

    logic [31:0]      data_q [LINES];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;

    assign rd_data_o  = data_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];

    // Tag/data RAM carries no reset; a write coinciding with reset is
    // dropped so a half-issued refill cannot leave stale contents behind.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (data_we_i) data_q[idx_i] <= data_i;
            if (tag_we_i)  tag_q[idx_i]  <= tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (valid_we_i) valid_q[idx_i] <= valid_i;
            if (dirty_we_i) dirty_q[idx_i] <= dirty_i;
        end
    end

endmodule

// File: rtl/wb_cache_dm.sv
// Direct-mapped, write-back, one-word-per-line cache for fetch and data access.
// Latency: hit/miss, rdata and memory port are combinational; array updates
//          and the hit/miss counters take effect at the next rising edge.
// Backpressure: none; the control FSM sequences writeback/update/memwrite and
//          each command completes in one clock against single-cycle memory.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   addr, wdata              byte address (bits [1:0] ignored), store data
//   req                      access strobe, feeds the statistics only
//   memwrite/writeback/update commands, priority writeback > update > memwrite
//   rdata, miss, dirty       line data, lookup miss, victim-dirty status
//   mem_addr/mem_wdata/mem_we/mem_rdata   backing memory port
//   hit_cnt, miss_cnt        saturating access statistics
module wb_cache_dm
    import wb_cache_dm_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              req,
    input  logic              memwrite,
    input  logic              writeback,
    input  logic              update,
    output logic [31:0]       rdata,
    output logic              miss,
    output logic              dirty,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TAG_W = tag_w(ADDR_W, INDEX_W);

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [TAG_W-1:0]   line_tag;
    logic [31:0]        line_data;
    logic               line_valid;
    logic               line_dirty;
    logic               hit;
    cmd_e               cmd;

    logic               data_we;
    logic [31:0]        data_wval;
    logic               tag_we;
    logic               valid_we;
    logic               dirty_we;
    logic               dirty_wval;

    logic [CNT_W-1:0]   hit_cnt_q,  hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    assign idx = INDEX_W'(idx_of(wide_t'(addr), INDEX_W));
    assign tag = TAG_W'(tag_of(wide_t'(addr), INDEX_W));

    wb_cache_dm_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_lines (
        .clk_i      (clk),
        .rst_ni     (rst),
        .idx_i      (idx),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .rd_valid_o (line_valid),
        .rd_dirty_o (line_dirty),
        .data_we_i  (data_we),
        .data_i     (data_wval),
        .tag_we_i   (tag_we),
        .tag_i      (tag),
        .valid_we_i (valid_we),
        .valid_i    (1'b1),
        .dirty_we_i (dirty_we),
        .dirty_i    (dirty_wval)
    );

    assign hit       = line_valid && (line_tag == tag);
    assign miss      = !hit;
    assign dirty     = line_valid && line_dirty;
    assign rdata     = line_data;
    assign mem_wdata = line_data;
    assign cmd       = pick_cmd(writeback, update, memwrite);

    // Only the array-write data source depends on the command.
    assign data_wval = (cmd == CMD_UPDATE) ? mem_rdata : wdata;

    always_comb begin
        data_we    = 1'b0;
        tag_we     = 1'b0;
        valid_we   = 1'b0;
        dirty_we   = 1'b0;
        dirty_wval = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = {tag, idx, 2'b00};
        case (cmd)
            CMD_WRITEBACK: begin
                // Victim address comes from the stored tag, not the request.
                mem_addr = {line_tag, idx, 2'b00};
                mem_we   = line_valid && line_dirty;
                dirty_we = 1'b1;
            end
            CMD_UPDATE: begin
                data_we  = 1'b1;
                tag_we   = 1'b1;
                valid_we = 1'b1;
                dirty_we = 1'b1;
            end
            CMD_STORE: begin
                // A store miss leaves the line alone; the FSM refills and retries.
                if (hit) begin
                    data_we    = 1'b1;
                    dirty_we   = 1'b1;
                    dirty_wval = 1'b1;
                end
            end
            default: ;
        endcase
        if (!rst) mem_we = 1'b0;
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (req) begin
            if (hit) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_wb_cache_dm.sv
// Self-checking bench for wb_cache_dm: directed steps then randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_cache_dm;

    localparam int INDEX_W = 6;
    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 4;
    localparam int LINES   = 1 << INDEX_W;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              req;
    logic              memwrite;
    logic              writeback;
    logic              update;
    logic [31:0]       rdata;
    logic              miss;
    logic              dirty;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    always #5 clk = ~clk;

    wb_cache_dm #(
        .INDEX_W (INDEX_W),
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .req       (req),
        .memwrite  (memwrite),
        .writeback (writeback),
        .update    (update),
        .rdata     (rdata),
        .miss      (miss),
        .dirty     (dirty),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: each slot remembers which word address it holds.
    bit          m_valid [LINES];
    bit          m_dirty [LINES];
    logic [31:0] m_waddr [LINES];
    logic [31:0] m_data  [LINES];
    int          m_hits;
    int          m_misses;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int slot(input logic [31:0] a);
        return int'((a / 4) % LINES);
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a - (a % 4);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[slot(a)] && (m_waddr[slot(a)] == word_of(a));
    endfunction

    // Compare every combinational and registered output to the model.
    task automatic check_outputs();
        int  s;
        bit  h;
        s = slot(addr);
        h = m_hit(addr);
        chk("miss", miss, !h);
        chk("dirty", dirty, m_valid[s] && m_dirty[s]);
        if (m_valid[s]) chk("rdata", rdata, m_data[s]);
        if (!rst) begin
            chk("mem_we_rst", mem_we, 0);
        end else if (writeback) begin
            chk("mem_we_wb", mem_we, m_valid[s] && m_dirty[s]);
            if (m_valid[s]) begin
                chk("mem_addr_wb", mem_addr, m_waddr[s]);
                chk("mem_wdata_wb", mem_wdata, m_data[s]);
            end
        end else begin
            chk("mem_we_idle", mem_we, 0);
            chk("mem_addr", mem_addr, word_of(addr));
        end
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_misses);
    endtask

    task automatic model_edge();
        int s;
        bit h;
        s = slot(addr);
        h = m_hit(addr);
        if (!rst) begin
            for (int i = 0; i < LINES; i++) begin
                m_valid[i] = 0;
                m_dirty[i] = 0;
            end
            m_hits   = 0;
            m_misses = 0;
        end else begin
            if (req) begin
                if (h) m_hits   = (m_hits   < CMAX) ? m_hits + 1   : CMAX;
                else   m_misses = (m_misses < CMAX) ? m_misses + 1 : CMAX;
            end
            if (writeback) begin
                m_dirty[s] = 0;
            end else if (update) begin
                m_data[s]  = mem_rdata;
                m_waddr[s] = word_of(addr);
                m_valid[s] = 1;
                m_dirty[s] = 0;
            end else if (memwrite && h) begin
                m_data[s]  = wdata;
                m_dirty[s] = 1;
            end
        end
    endtask

    // Check before the edge, advance the model at the edge, resume just after.
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_cmds();
        memwrite  = 1'b0;
        writeback = 1'b0;
        update    = 1'b0;
    endtask

    initial begin
        rst = 1'b0; addr = '0; wdata = '0; req = 1'b0; mem_rdata = '0;
        idle_cmds();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 0; m_dirty[i] = 0; m_waddr[i] = '0; m_data[i] = '0;
        end
        m_hits = 0; m_misses = 0;

        // 1: reset, then a counted miss at 0x40.
        step();
        step();
        rst = 1'b1; addr = 32'h40; req = 1'b1;
        #1;
        chk("t1_miss", miss, 1);
        chk("t1_dirty", dirty, 0);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_hit_cnt_reset", hit_cnt, 0);
        chk("t1_miss_cnt_reset", miss_cnt, 0);
        step();
        chk("t1_miss_cnt", miss_cnt, 1);

        // 2: refill then a counted hit.
        req = 1'b0; update = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        idle_cmds(); req = 1'b1;
        #1;
        chk("t2_miss", miss, 0);
        chk("t2_rdata", rdata, 32'hDEADBEEF);
        step();
        chk("t2_hit_cnt", hit_cnt, 1);

        // 3: store hit.
        req = 1'b0; memwrite = 1'b1; wdata = 32'h12345678;
        step();
        idle_cmds();
        #1;
        chk("t3_rdata", rdata, 32'h12345678);
        chk("t3_dirty", dirty, 1);

        // 4: conflicting address sees the dirty victim; flush it.
        addr = 32'h40 + (32'd4 << INDEX_W);
        #1;
        chk("t4_miss", miss, 1);
        chk("t4_dirty", dirty, 1);
        writeback = 1'b1;
        #1;
        chk("t4_mem_we", mem_we, 1);
        chk("t4_mem_addr", mem_addr, 32'h40);
        chk("t4_mem_wdata", mem_wdata, 32'h12345678);
        step();
        idle_cmds();
        #1;
        chk("t4_dirty_after", dirty, 0);

        // 5: all three commands together -> only the writeback acts.
        addr = 32'h40; memwrite = 1'b1; wdata = 32'hA5A5A5A5;
        step();
        writeback = 1'b1; update = 1'b1; memwrite = 1'b1;
        wdata = 32'h11111111; mem_rdata = 32'h22222222;
        #1;
        chk("t5_mem_we", mem_we, 1);
        step();
        idle_cmds();
        #1;
        chk("t5_miss", miss, 0);
        chk("t5_rdata", rdata, 32'hA5A5A5A5);
        chk("t5_dirty", dirty, 0);
        writeback = 1'b1;
        #1;
        chk("t5_clean_wb_we", mem_we, 0);
        step();
        idle_cmds();

        // 6: miss counter saturation, then reset during a refill.
        addr = 32'h40 + (32'd4 << INDEX_W); req = 1'b1;
        for (int i = 0; i < CMAX + 4; i++) step();
        chk("t6_miss_sat", miss_cnt, CMAX);
        step();
        chk("t6_miss_sat_hold", miss_cnt, CMAX);
        rst = 1'b0; update = 1'b1; addr = 32'h80; mem_rdata = 32'hCAFEF00D;
        step();
        rst = 1'b1; idle_cmds(); req = 1'b0;
        #1;
        chk("t6_rst_miss", miss, 1);
        chk("t6_rst_hit_cnt", hit_cnt, 0);
        chk("t6_rst_miss_cnt", miss_cnt, 0);
        rst = 1'b0; writeback = 1'b1;
        #1;
        chk("t6_rst_mem_we", mem_we, 0);
        step();
        rst = 1'b1; idle_cmds();

        // Random traffic over a few slots and tags to force conflicts.
        for (int n = 0; n < 600; n++) begin
            int r;
            addr      = ($urandom_range(0, 2) << (INDEX_W + 2))
                      | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            wdata     = $urandom;
            mem_rdata = $urandom;
            req       = 1'($urandom_range(0, 1));
            r         = int'($urandom_range(0, 99));
            writeback = (r < 20);
            update    = (r >= 15 && r < 45);
            memwrite  = (r >= 40 && r < 80);
            rst       = !($urandom_range(0, 99) < 2);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
